div47_reconstruct_seq: RTL and testbench

// - Inverse of the 60-bit divide-by-47 quotient logic: rebuilds the dividend as x = q*47 + r.
// - Sequential; processes one 6-bit quotient digit per clock, MSB first.
// - Sits after the divider as a datapath self-check and residue-to-integer converter.
// - Flags a remainder out of range and an overflow past 60 bits.

---
 rtl/div47_reconstruct_seq_pkg.sv | 29 ++
 rtl/div47_reconstruct_seq_mul47_digit.sv | 14 +
 rtl/div47_reconstruct_seq.sv | 120 ++++++++++++
 tb/tb_div47_reconstruct_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div47_reconstruct_seq_pkg.sv
// div47_pkg: shared widths, FSM state type and the remainder range check
// for the divide-by-47 reconstruction datapath.
//   N_BITS   - dividend width
//   DIVISOR  - constant multiplier (47)
//   Q_BITS   - quotient width
//   R_BITS   - remainder width
//   DIGIT    - quotient bits consumed per clock
//   N_DIGITS - digits per quotient (q is zero-extended to N_BITS)
package div47_pkg;

    localparam int unsigned N_BITS   = 60;
    localparam int unsigned DIVISOR  = 47;
    localparam int unsigned Q_BITS   = 55;
    localparam int unsigned R_BITS   = 6;
    localparam int unsigned DIGIT    = 6;
    localparam int unsigned N_DIGITS = (N_BITS + DIGIT - 1) / DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when r is a legal remainder for the divisor.
    function automatic logic rem_ok(input logic [R_BITS-1:0] r);
        return r < R_BITS'(DIVISOR);
    endfunction

endpackage

// File: rtl/div47_reconstruct_seq_mul47_digit.sv
// mul47_digit: combinational multiply of one 6-bit quotient digit by 47.
//   d - quotient digit
//   p - d*47, built as (d<<5)+(d<<3)+(d<<2)+(d<<1)+d
module mul47_digit (
    input  logic [5:0]  d,
    output logic [11:0] p
);

    logic [11:0] dx;

    assign dx = {6'b0, d};
    assign p  = (dx << 5) + (dx << 3) + (dx << 2) + (dx << 1) + dx;

endmodule

// File: rtl/div47_reconstruct_seq.sv
// div47_reconstruct_seq: rebuilds x = q*47 + r one quotient digit per clock,
// most significant digit first (Horner: acc = acc*64 + d*47).
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - q/r presented
//   in_ready   - block can accept this cycle
//   in_q       - quotient (55 bits)
//   in_r       - remainder (6 bits)
//   out_valid  - result held
//   out_ready  - consumer takes result
//   out_x      - reconstructed dividend, low 60 bits
//   out_ovf    - q*47+r >= 2^60
//   out_err    - in_r >= 47
module div47_reconstruct_seq
    import div47_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Q_BITS-1:0]   in_q,
    input  logic [R_BITS-1:0]   in_r,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   out_x,
    output logic                out_ovf,
    output logic                out_err
);

    typedef logic [N_BITS:0] sum_t;

    state_t              state, state_nxt;
    logic [N_BITS-1:0]   shreg;
    logic [N_BITS-1:0]   acc;
    logic [3:0]          cnt;
    logic [R_BITS-1:0]   r_q;
    logic                ovf;
    logic                err;

    logic                accept;
    logic                step;
    logic                last;
    logic [DIGIT-1:0]    d;
    logic [11:0]         prod;
    logic                lost;
    sum_t                sum;

    assign d = shreg[N_BITS-1 -: DIGIT];

    mul47_digit u_mul47 (
        .d (d),
        .p (prod)
    );

    // One Horner step. The top digit of acc falls off on the shift; any set
    // bit there, or a carry out of the add, means the true value needs more
    // than N_BITS bits. The remainder joins the final add only.
    always_comb begin
        lost = |acc[N_BITS-1 -: DIGIT];
        sum  = sum_t'({acc[N_BITS-DIGIT-1:0], {DIGIT{1'b0}}})
             + sum_t'(prod)
             + (last ? sum_t'(r_q) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        accept    = in_valid & in_ready;
        step      = (state == RUN);
        last      = step & (cnt == 4'(N_DIGITS - 1));
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            r_q   <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            shreg <= N_BITS'(in_q);
            acc   <= '0;
            cnt   <= '0;
            r_q   <= in_r;
            ovf   <= 1'b0;
            err   <= ~rem_ok(in_r);
        end else if (step) begin
            acc   <= sum[N_BITS-1:0];
            ovf   <= ovf | lost | sum[N_BITS];
            shreg <= shreg << DIGIT;
            cnt   <= cnt + 4'd1;
        end
    end

    assign out_x   = acc;
    assign out_ovf = ovf;
    assign out_err = err;

endmodule

// File: tb/tb_div47_reconstruct_seq.sv
module tb_div47_reconstruct_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [54:0] in_q;
    logic [5:0]  in_r;
    logic        out_valid;
    logic        out_ready;
    logic [59:0] out_x;
    logic        out_ovf;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div47_reconstruct_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer value of q*47 + r in 64 bits.
    function automatic logic [63:0] ref_full(input logic [54:0] q, input logic [5:0] r);
        return 64'(q) * 64'd47 + 64'(r);
    endfunction

    task automatic send(input logic [54:0] q, input logic [5:0] r, input string tag);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick;
            n++;
        end
        chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_q     = q;
        in_r     = r;
        tick;
        in_valid = 1'b0;
        in_q     = 55'({$urandom, $urandom});
        in_r     = 6'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 30) begin
            tick;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'd10);
    endtask

    task automatic check_out(input logic [54:0] q, input logic [5:0] r, input string tag);
        logic [63:0] full;
        full = ref_full(q, r);
        chk({tag, "/valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/x"},     64'(out_x),     64'(full[59:0]));
        chk({tag, "/ovf"},   64'(out_ovf),   64'(full[63:60] != 4'd0));
        chk({tag, "/err"},   64'(out_err),   64'(r >= 6'd47));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "/drop"},  64'(out_valid), 64'd0);
        chk({tag, "/idle"},  64'(in_ready),  64'd1);
    endtask

    task automatic txn(input logic [54:0] q, input logic [5:0] r, input string tag);
        send(q, r, tag);
        chk({tag, "/busy"}, 64'(in_ready), 64'd0);
        wait_done(tag);
        check_out(q, r, tag);
    endtask

    initial begin
        logic [63:0] t;
        logic [54:0] qmax;
        logic [59:0] x;
        logic [54:0] q;
        logic [5:0]  r;
        logic [59:0] held_x;
        logic        held_ovf, held_err;
        logic [54:0] bq[4];
        logic [5:0]  br[4];
        int          gap;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_q      = '0;
        in_r      = '0;
        repeat (3) tick;
        chk("reset/valid", 64'(out_valid), 64'd0);
        chk("reset/x",     64'(out_x),     64'd0);
        chk("reset/ovf",   64'(out_ovf),   64'd0);
        chk("reset/err",   64'(out_err),   64'd0);
        rst = 1'b0;
        tick;
        chk("reset/ready", 64'(in_ready),  64'd1);

        txn(55'd0, 6'd0, "zero");
        chk("zero/const", 64'(out_x), 64'd0);
        take("zero");

        txn(55'd1, 6'd46, "q1r46");
        chk("q1r46/const", 64'(out_x), 64'd93);
        take("q1r46");

        txn(55'd2, 6'd47, "q2r47");
        chk("q2r47/const", 64'(out_x), 64'd141);
        chk("q2r47/errc",  64'(out_err), 64'd1);
        take("q2r47");

        t    = (64'd1 << 60) - 64'd28;
        qmax = 55'(t / 64'd47);
        txn(qmax, 6'd27, "allones");
        chk("allones/const", 64'(out_x), 64'h0FFF_FFFF_FFFF_FFFF);
        chk("allones/ovfc",  64'(out_ovf), 64'd0);
        take("allones");

        txn(qmax + 55'd1, 6'd0, "wrap");
        chk("wrap/const", 64'(out_x), 64'd19);
        chk("wrap/ovfc",  64'(out_ovf), 64'd1);
        take("wrap");

        for (int i = 0; i < 8; i++) begin
            x = 60'({$urandom, $urandom});
            q = 55'(x / 60'd47);
            r = 6'(x % 60'd47);
            txn(q, r, "rand");
            chk("rand/xeq", 64'(out_x), 64'(x));
            take("rand");
        end

        x = 60'({$urandom, $urandom});
        q = 55'(x / 60'd47);
        r = 6'(x % 60'd47);
        txn(q, r, "hold");
        held_x   = out_x;
        held_ovf = out_ovf;
        held_err = out_err;
        in_valid = 1'b1;
        in_q     = 55'd5;
        in_r     = 6'd5;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold/valid", 64'(out_valid), 64'd1);
            chk("hold/ready", 64'(in_ready),  64'd0);
            chk("hold/x",     64'(out_x),     64'(x));
            chk("hold/xst",   64'(out_x),     64'(held_x));
            chk("hold/ovf",   64'(out_ovf),   64'(held_ovf));
            chk("hold/err",   64'(out_err),   64'(held_err));
        end
        in_valid = 1'b0;
        take("hold");

        for (int i = 0; i < 4; i++) begin
            bq[i] = 55'({$urandom, $urandom});
            br[i] = 6'($urandom_range(0, 63));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_q      = bq[0];
        in_r      = br[0];
        chk("b2b/first", 64'(in_ready), 64'd1);
        tick;
        for (int i = 1; i < 4; i++) begin
            in_q = bq[i];
            in_r = br[i];
            gap  = 0;
            while (!in_ready && gap < 30) begin
                tick;
                gap++;
            end
            check_out(bq[i-1], br[i-1], "b2b");
            tick;
            gap++;
            chk("b2b/gap", 64'(gap), 64'd11);
            chk("b2b/run", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        wait_done("b2b_last");
        check_out(bq[3], br[3], "b2b_last");
        take("b2b_last");

        send(55'($urandom), 6'd50, "rst");
        repeat (4) tick;
        chk("rst/errmid", 64'(out_err), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst/valid", 64'(out_valid), 64'd0);
        chk("rst/ready", 64'(in_ready),  64'd1);
        chk("rst/x",     64'(out_x),     64'd0);
        chk("rst/ovf",   64'(out_ovf),   64'd0);
        chk("rst/err",   64'(out_err),   64'd0);
        repeat (12) begin
            tick;
            chk("rst/stay", 64'(out_valid), 64'd0);
        end
        txn(55'd3, 6'd1, "after_rst");
        chk("after_rst/const", 64'(out_x), 64'd142);
        take("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
